hdx_bus_port: RTL

- Half-duplex tri-state bus port. Transmits host words onto a shared bidirectional data line and receives words driven by a remote peer on the same line.
- This is the receive/transmit end of a driver-based bus: this block decides when it drives the wire and when it only senses it.
- It inserts high-Z turnaround cycles whenever the direction changes, so two drivers never fight.
- Sits between a host datapath and an off-block wired bus shared with one peer port.

---
 rtl/hdx_bus_port.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hdx_bus_port.sv
// hdx_bus_port
//   Half-duplex tri-state bus port. Sends host words onto a shared
//   bidirectional data line and receives words that a remote peer drives onto
//   the same line. High-Z turnaround cycles are inserted on every change of
//   direction so the two ends never drive the wire at the same time.
//
// Build option:
//   PARITY_EN  adds an even-parity bit as the bus MSB. The port drives it,
//              checks it on receive, and reports mismatches on rx_perr.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   clrn       asynchronous active-low reset; releases the bus at once
//   tx_valid   host has a word to send
//   tx_data    word to send
//   tx_ready   port can accept a tx word (high only in RX_IDLE)
//   rx_valid   a received word is held in rx_data
//   rx_data    received word
//   rx_ready   host consumes the rx word
//   bus_data   shared wire, W bits (W+1 with PARITY_EN); high-Z unless driving
//   bus_oe     1 while this port drives bus_data
//   bus_stb_o  strobe to the peer: data on the bus is valid
//   bus_stb_i  strobe from the peer
//   clr_err    clears the sticky error flags
//   rx_ovf     sticky: word arrived while rx_valid=1 and rx_ready=0
//   coll       sticky: bus_stb_i seen outside RX_IDLE
//   rx_perr    sticky: received parity mismatch (PARITY_EN only)
//
// State table:
//   RX_IDLE | bus released, sampling peer strobes, tx word accepted here
//   TA_OUT  | bus high-Z for TA cycles before this port starts driving
//   DRIVE   | bus driven with tx_reg for HOLD cycles, strobe on the last one
//   TA_IN   | bus high-Z for TA cycles before the peer may drive again

module hdx_bus_port #(
  parameter int W    = 8,
  parameter int TA   = 1,
  parameter int HOLD = 2
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [W-1:0] rx_data,
  input  logic         rx_ready,
`ifdef PARITY_EN
  inout  wire  [W:0]   bus_data,
`else
  inout  wire  [W-1:0] bus_data,
`endif
  output logic         bus_oe,
  output logic         bus_stb_o,
  input  logic         bus_stb_i,
  input  logic         clr_err,
`ifdef PARITY_EN
  output logic         rx_perr,
`endif
  output logic         rx_ovf,
  output logic         coll
);

  localparam int MAXC = (TA > HOLD) ? TA : HOLD;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    TA_OUT  = 2'd1,
    DRIVE   = 2'd2,
    TA_IN   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  tx_reg;

  logic          idle;
  logic          sample_stb;
  logic          slot_free;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= RX_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. The counter holds the cycles left in the current state
  // minus one; it is reloaded on every transition and only decremented while
  // nonzero, so it can never wrap.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RX_IDLE: begin
        if (tx_valid) begin
          state_nxt = TA_OUT;
          cnt_nxt   = CW'(TA - 1);
        end
      end
      TA_OUT: begin
        if (cnt == '0) begin
          state_nxt = DRIVE;
          cnt_nxt   = CW'(HOLD - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_nxt = TA_IN;
          cnt_nxt   = CW'(TA - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      TA_IN: begin
        if (cnt == '0) begin
          state_nxt = RX_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = RX_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Decoded straight from the state register so that an
  // asynchronous reset drops bus_oe without waiting for a clock.
  // ---------------------------------------------------------------------
  always_comb begin
    tx_ready  = 1'b0;
    bus_oe    = 1'b0;
    bus_stb_o = 1'b0;
    unique case (state)
      RX_IDLE: tx_ready = 1'b1;
      DRIVE: begin
        bus_oe    = 1'b1;
        bus_stb_o = (cnt == '0);
      end
      default: begin
        tx_ready  = 1'b0;
        bus_oe    = 1'b0;
        bus_stb_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus driver
  // ---------------------------------------------------------------------
`ifdef PARITY_EN
  logic [W:0] drive_word;
  assign drive_word = {^tx_reg, tx_reg};
`else
  logic [W-1:0] drive_word;
  assign drive_word = tx_reg;
`endif

  assign bus_data = bus_oe ? drive_word : 'z;

  // ---------------------------------------------------------------------
  // Transmit holding register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_reg <= '0;
    end else if (state == RX_IDLE && tx_valid) begin
      tx_reg <= tx_data;
    end
  end

  // ---------------------------------------------------------------------
  // Receive path and sticky errors. The slot counts as free when the host
  // is consuming the held word in the same cycle a new one arrives.
  // ---------------------------------------------------------------------
  assign idle       = (state == RX_IDLE);
  assign sample_stb = idle && bus_stb_i;
  assign slot_free  = !rx_valid || rx_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (sample_stb && slot_free) begin
      rx_valid <= 1'b1;
      rx_data  <= bus_data[W-1:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_ovf <= 1'b0;
      coll   <= 1'b0;
    end else begin
      rx_ovf <= (rx_ovf && !clr_err) || (sample_stb && !slot_free);
      coll   <= (coll && !clr_err) || (bus_stb_i && !idle);
    end
  end

`ifdef PARITY_EN
  logic perr_now;
  assign perr_now = sample_stb && (bus_data[W] != ^bus_data[W-1:0]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_perr <= 1'b0;
    end else begin
      rx_perr <= (rx_perr && !clr_err) || perr_now;
    end
  end
`endif

endmodule
